// File: rtl/fir_out_buffer_pkg.sv
// Shared constants and helpers for the FIR chain and its output buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_out_buffer_pkg;

    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = 4;

    // Magnitude of a signed sample; the most negative value has no positive
    // counterpart in DATA_W bits, so it saturates to the largest positive.
    function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] d);
        if (!d[DATA_W-1]) begin
            return d;
        end
        if (d == {1'b1, {(DATA_W-1){1'b0}}}) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
        return '0 - d;
    endfunction

endpackage

// File: rtl/fir_buf_mem.sv
// Register-file storage for the FIR output FIFO: one write port, one async read port.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none; the caller decides when to write.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). No reset on the array.
module fir_buf_mem
    import fir_out_buffer_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fir_out_buffer.sv
// FIFO between FIR output and downstream, with overflow flag, peak |sample| and sample count.
// Latency: a pushed sample appears at out_data one cycle after the push edge (FWFT, no bypass).
// Backpressure: out_valid/out_ready on the output; input cannot stall, a sample arriving
//               to a full FIFO with no pop that cycle is dropped and overflow sticks.
// Ports: clk, rst (async active-low), clr (sync), fir_valid/fir_d in, out_valid/out_ready/
//        out_data out, status fifo_cnt, overflow, peak_abs, sample_cnt.
module fir_out_buffer
    import fir_out_buffer_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              fir_valid,
    input  logic [DATA_W-1:0] fir_d,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [AW:0]       fifo_cnt,
    output logic              overflow,
    output logic [DATA_W-1:0] peak_abs,
    output logic [15:0]       sample_cnt
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              pop;
    logic              push;
    logic              wr_en;
    logic [DATA_W-1:0] push_abs;

    assign out_valid = (fifo_cnt != '0);
    assign full      = (fifo_cnt == FULL_CNT);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = fir_valid & (~full | pop);
    assign wr_en     = push & ~clr;
    assign push_abs  = abs_sat(fir_d);

    fir_buf_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (fir_d),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            overflow   <= 1'b0;
            peak_abs   <= '0;
            sample_cnt <= '0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            overflow   <= 1'b0;
            peak_abs   <= '0;
            sample_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (fir_valid && !push) begin
                overflow <= 1'b1;
            end
            if (push) begin
                sample_cnt <= sample_cnt + 16'd1;
                if (push_abs > peak_abs) begin
                    peak_abs <= push_abs;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_out_buffer.sv
module tb_fir_out_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        fir_valid;
    logic [15:0] fir_d;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [4:0]  fifo_cnt;
    logic        overflow;
    logic [15:0] peak_abs;
    logic [15:0] sample_cnt;

    fir_out_buffer #(.DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .fir_valid  (fir_valid),
        .fir_d      (fir_d),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .fifo_cnt   (fifo_cnt),
        .overflow   (overflow),
        .peak_abs   (peak_abs),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: a plain queue plus scalar statistics.
    logic [15:0] mq[$];
    int          m_peak = 0;
    int          m_scnt = 0;
    bit          m_ovf  = 0;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        rdy;
        logic        c;
        logic        e_vld;
        logic [4:0]  e_cnt;
        logic [15:0] e_data;
        logic [15:0] e_peak;
        logic [15:0] e_scnt;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_peak = 0;
        m_scnt = 0;
        m_ovf  = 0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] d, input logic r, input logic c);
        int  sv;
        int  a;
        bit  do_pop;
        bit  do_push;
        if (c) begin
            model_reset();
            return;
        end
        do_pop  = (mq.size() != 0) && r;
        do_push = v && ((mq.size() < 16) || do_pop);
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(d);
            sv = int'($signed(d));
            a  = (sv < 0) ? -sv : sv;
            if (a > 32767) a = 32767;
            if (a > m_peak) m_peak = a;
            m_scnt = (m_scnt + 1) % 65536;
        end else if (v) begin
            m_ovf = 1;
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [15:0] d, input logic r, input logic c);
        fir_valid = v;
        fir_d     = d;
        out_ready = r;
        clr       = c;
        @(posedge clk);
        #1;
        model_step(v, d, r, c);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".vld"},  32'(out_valid),  32'(mq.size() != 0));
        chk({tag, ".cnt"},  32'(fifo_cnt),   32'(mq.size()));
        chk({tag, ".ovf"},  32'(overflow),   32'(m_ovf));
        chk({tag, ".peak"}, 32'(peak_abs),   32'(m_peak));
        chk({tag, ".scnt"}, 32'(sample_cnt), 32'(m_scnt));
        if (mq.size() != 0) chk({tag, ".data"}, 32'(out_data), 32'(mq[0]));
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; fir_valid = 1'b0; fir_d = '0; out_ready = 1'b0;
        model_reset();
        #2;
        chk("rst.vld", 32'(out_valid), 32'd0);
        chk("rst.cnt", 32'(fifo_cnt), 32'd0);
        chk("rst.ovf", 32'(overflow), 32'd0);
        chk("rst.peak", 32'(peak_abs), 32'd0);
        chk("rst.scnt", 32'(sample_cnt), 32'd0);
        #10 rst = 1'b1;

        //        v  d          rdy c  vld cnt data       peak       scnt  ovf
        tbl[0] = '{1, 16'h0123, 0, 0, 1, 1, 16'h0123, 16'h0123, 16'd1, 0};
        tbl[1] = '{1, 16'h0007, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'd0, 0};
        tbl[2] = '{1, 16'hFFFB, 0, 0, 1, 1, 16'hFFFB, 16'h0005, 16'd1, 0};
        tbl[3] = '{1, 16'h0007, 1, 0, 1, 1, 16'h0007, 16'h0007, 16'd2, 0};
        tbl[4] = '{1, 16'h8000, 0, 0, 1, 2, 16'h0007, 16'h7FFF, 16'd3, 0};
        tbl[5] = '{0, 16'h0000, 1, 0, 1, 1, 16'h8000, 16'h7FFF, 16'd3, 0};
        tbl[6] = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h7FFF, 16'd3, 0};
        tbl[7] = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h7FFF, 16'd3, 0};
        tbl[8] = '{1, 16'h1234, 1, 0, 1, 1, 16'h1234, 16'h7FFF, 16'd4, 0};
        tbl[9] = '{0, 16'h0000, 0, 0, 1, 1, 16'h1234, 16'h7FFF, 16'd4, 0};

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].c);
            chk($sformatf("tbl%0d.vld", i),  32'(out_valid),  32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d.cnt", i),  32'(fifo_cnt),   32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.peak", i), 32'(peak_abs),   32'(tbl[i].e_peak));
            chk($sformatf("tbl%0d.scnt", i), 32'(sample_cnt), 32'(tbl[i].e_scnt));
            chk($sformatf("tbl%0d.ovf", i),  32'(overflow),   32'(tbl[i].e_ovf));
            if (tbl[i].e_vld) chk($sformatf("tbl%0d.data", i), 32'(out_data), 32'(tbl[i].e_data));
        end

        // Overflow: 17 pushes with no pop, then drain in order.
        cyc(0, 0, 0, 1);
        for (int i = 1; i <= 17; i++) cyc(1, 16'(i), 0, 0);
        chk("ovf17.cnt", 32'(fifo_cnt), 32'd16);
        chk("ovf17.ovf", 32'(overflow), 32'd1);
        chk("ovf17.scnt", 32'(sample_cnt), 32'd16);
        chk("ovf17.peak", 32'(peak_abs), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d.data", i), 32'(out_data), 32'(i));
            cyc(0, 0, 1, 0);
        end
        chk("drain.vld", 32'(out_valid), 32'd0);
        chk("drain.cnt", 32'(fifo_cnt), 32'd0);

        // Full FIFO with simultaneous push and pop: nothing dropped.
        cyc(0, 0, 0, 1);
        for (int i = 1; i <= 16; i++) cyc(1, 16'(i), 0, 0);
        cyc(1, 16'd100, 1, 0);
        chk("fullpp.cnt", 32'(fifo_cnt), 32'd16);
        chk("fullpp.ovf", 32'(overflow), 32'd0);
        chk("fullpp.scnt", 32'(sample_cnt), 32'd17);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fullpp.d%0d", i), 32'(out_data), (i == 15) ? 32'd100 : 32'(i + 2));
            cyc(0, 0, 1, 0);
        end
        chk("fullpp.empty", 32'(out_valid), 32'd0);

        // Wrap pointers with interleaved pops, then clr beats a concurrent push.
        for (int i = 0; i < 20; i++) cyc(1, 16'(i * 3 + 1), 1'(i % 2), 0);
        check_model("wrap");
        cyc(1, 16'h0055, 1, 1);
        chk("clr.cnt", 32'(fifo_cnt), 32'd0);
        chk("clr.vld", 32'(out_valid), 32'd0);
        chk("clr.ovf", 32'(overflow), 32'd0);
        chk("clr.scnt", 32'(sample_cnt), 32'd0);
        chk("clr.peak", 32'(peak_abs), 32'd0);

        // Asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 3; i++) cyc(1, 16'(i + 9), 0, 0);
        cyc(0, 0, 0, 0);
        chk("pre_rst.cnt", 32'(fifo_cnt), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("async_rst.vld", 32'(out_valid), 32'd0);
        chk("async_rst.cnt", 32'(fifo_cnt), 32'd0);
        model_reset();
        #2 rst = 1'b1;
        cyc(1, 16'h00AA, 1, 0);
        chk("post_rst.vld", 32'(out_valid), 32'd1);
        chk("post_rst.data", 32'(out_data), 32'h00AA);
        chk("post_rst.cnt", 32'(fifo_cnt), 32'd1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            logic        v;
            logic        r;
            logic        c;
            logic [15:0] d;
            v = 1'(($urandom % 100) < 60);
            r = ((i / 64) % 2 == 0) ? 1'(($urandom % 100) < 30) : 1'(($urandom % 100) < 75);
            c = 1'(($urandom % 200) == 0);
            d = 16'($urandom);
            if (($urandom % 50) == 0) d = 16'h8000;
            cyc(v, d, r, c);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fir_out_buffer.md
FIR_OUT_BUFFER -- requirements
Module: fir_out_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of FIFO entries (power of two, min 4).
REQ-002 Parameter AW, default 4, pointer width, log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous clear of all state, active-high.
REQ-006 fir_valid  input  1  FIR output sample strobe; one sample per high cycle.
REQ-007 fir_d  input  16  FIR output sample, signed two's complement.
REQ-008 out_ready  input  1  downstream accepts head entry this cycle.
REQ-009 out_valid  output  1  FIFO non-empty; out_data is meaningful.
REQ-010 out_data  output  16  head-of-FIFO sample, first-word-fall-through.
REQ-011 fifo_cnt  output  AW+1  current occupancy, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag: at least one sample was dropped.
REQ-013 peak_abs  output  16  largest |fir_d| accepted since reset/clr.
REQ-014 sample_cnt  output  16  number of accepted samples, modulo 2^16.

Function
REQ-015 Push: fir_valid=1 and (fifo_cnt<DEPTH or pop this cycle) writes fir_d at wr_ptr; wr_ptr increments, wrapping DEPTH-1 -> 0.
REQ-016 Pop: out_valid=1 and out_ready=1 removes head; rd_ptr increments with the same wrap.
REQ-017 out_valid SHALL equal (fifo_cnt!=0); out_data SHALL equal mem[rd_ptr] combinationally.
REQ-018 Push into empty FIFO: out_valid rises the cycle after the push edge (latency 1); no bypass in the push cycle.
REQ-019 Simultaneous push and pop: fifo_cnt unchanged, both pointers advance; allowed when full (no drop) and when cnt=1.
REQ-020 Pop when empty is ignored; out_ready is don't-care with out_valid=0.
REQ-021 Push when full without pop: sample dropped, memory/pointers unchanged, overflow set to 1 next edge and held.
REQ-022 fifo_cnt: +1 on push only, -1 on pop only, else unchanged; never exceeds DEPTH or underflows.
REQ-023 peak_abs: on each accepted push, abs = fir_d if non-negative else -fir_d; -32768 saturates to 32767; peak_abs <= max(peak_abs, abs).
REQ-024 Dropped samples SHALL NOT update peak_abs or sample_cnt.
REQ-025 sample_cnt increments on each accepted push; 65535 wraps to 0.
REQ-026 clr=1: pointers, fifo_cnt, overflow, peak_abs, sample_cnt to 0 next edge; clr overrides same-cycle push and pop; memory contents need not clear.
REQ-027 out_data while out_valid=0 is unspecified; checkers SHALL NOT compare it.

Reset
REQ-028 rst=0 asynchronously forces wr_ptr, rd_ptr, fifo_cnt, overflow, peak_abs, sample_cnt to 0; out_valid=0 immediately.
REQ-029 Reset mid-operation discards all buffered samples; first push after release behaves as into empty FIFO.
REQ-030 Memory array SHALL NOT be reset (register file, no reset net).

Structure
REQ-031 Shared package holds DATA_W=16 and default DEPTH/AW constants used by FIR chain and this buffer.
REQ-032 One sub-module fir_buf_mem (DEPTH x 16 storage, one write port, one async read port); control, counters and peak logic live in the top.

Verification
REQ-033 Reset then fir_valid 1 cycle with fir_d=16'h0123 -> next cycle out_valid=1, out_data=16'h0123, fifo_cnt=1, sample_cnt=1, peak_abs=16'h0123.
REQ-034 out_ready=0, push 17 samples 1..17 -> fifo_cnt=16, overflow=1, sample_cnt=16; then drain -> out_data 1..16 in order, out_valid=0 after 16th pop.
REQ-035 FIFO full, fir_valid=1 and out_ready=1 same cycle with fir_d=100 -> no drop, overflow stays 0, fifo_cnt stays 16, 100 popped last.
REQ-036 Push -5, 7, -32768 -> peak_abs sequence 5, 7, 32767.
REQ-037 Push 20 with wraps interleaved pops, then clr=1 concurrent with fir_valid=1 -> next cycle fifo_cnt=0, out_valid=0, overflow=0, sample_cnt=0, peak_abs=0.
REQ-038 3 samples buffered, rst pulsed low mid-cycle -> out_valid, fifo_cnt drop to 0 without clock edge; push 16'h00AA after release -> out_data=16'h00AA.
